axi4lite_cmd_master: RTL and testbench
======================================

// Module: axi4lite_cmd_master
// PURPOSE
//  AXI4-Lite master: converts a single-beat command/response interface into AXI4-Lite read/write bursts.
//  Sits in the PL. Drives the AXI4-Lite slave register banks (pulse generator regs) for self-test and sequencing without the PS.
//  One outstanding transaction max; a watchdog flags stalled slaves.
// PARAMETERS
//  C_M_AXI_DATA_WIDTH  32  data width; only 32 supported
//  C_M_AXI_ADDR_WIDTH  4   address width
//  TIMEOUT_CYCLES      1024  stall watchdog limit; 0 = watchdog disabled
// PORTS
//  M_AXI_ACLK                   in   1      clock, all logic rising-edge
//  M_AXI_ARESETN                in   1      reset, asynchronous, active-low
//  M_AXI_AWADDR                 out  AW     write address, held from AW issue until the AW handshake
//  M_AXI_AWPROT / M_AXI_ARPROT  out  3      constant 3'b000
//  M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  AW handshake
//  M_AXI_WDATA                  out  DW     write data
//  M_AXI_WSTRB                  out  DW/8   write strobes
//  M_AXI_WVALID / M_AXI_WREADY  out/in  1   W handshake
//  M_AXI_BRESP                  in   2      write response
//  M_AXI_BVALID / M_AXI_BREADY  in/out  1   B handshake
//  M_AXI_ARADDR                 out  AW     read address
//  M_AXI_ARVALID / M_AXI_ARREADY  out/in  1  AR handshake
//  M_AXI_RDATA                  in   DW     read data
//  M_AXI_RRESP                  in   2      read response
//  M_AXI_RVALID / M_AXI_RREADY  in/out  1   R handshake
//  cmd_valid / cmd_ready        in/out  1   command handshake
//  cmd_write                    in   1      1 = write, 0 = read
//  cmd_addr                     in   AW     target byte address
//  cmd_wdata                    in   DW     write data; ignored for reads
//  cmd_wstrb                    in   DW/8   byte enables; ignored for reads
//  rsp_valid / rsp_ready        out/in  1   response handshake
//  rsp_rdata                    out  DW     read data; 0 after writes
//  rsp_resp                     out  2      captured BRESP/RRESP
//  timeout_err                  out  1      sticky watchdog flag
// BEHAVIOUR
//  Reset: all outputs, VALID/READY signals, and address/data registers = 0; FSM = IDLE; watchdog counter = 0.
//  FSM:
//  - IDLE: cmd_ready=1. cmd_valid -> latch cmd_*, clear timeout_err.
//    - Write: go to WADDR. Read: go to RADDR.
//  - WADDR: AWVALID and WVALID rise together, one cycle after acceptance. Each drops independently after its own handshake (VALID&&READY).
//    - Once both handshakes have completed (same cycle or different cycles), go to WRESP.
//  - WRESP: BREADY=1. On BVALID: capture BRESP, rsp_rdata=0, go to RSP.
//  - RADDR: ARVALID=1 until ARREADY; then go to RDATA.
//  - RDATA: RREADY=1. On RVALID: capture RDATA/RRESP, go to RSP.
//  - RSP: rsp_valid=1, outputs stable until rsp_ready; then go to IDLE.
//    - A new command is accepted no earlier than the cycle after the response handshake.
//  VALID signals never drop before their handshake. Once a VALID is asserted, its address/data are stable.
//  cmd_ready=0 in every state except IDLE.
//  Watchdog:
//  - Counts cycles spent in WADDR/WRESP/RADDR/RDATA; resets to 0 on every state change.
//  - On reaching TIMEOUT_CYCLES: set timeout_err. No abort; the transaction continues (AXI forbids withdrawing VALID).
//  - timeout_err is cleared only at the next command acceptance.
//  - Disabled when TIMEOUT_CYCLES=0.
//  Non-OKAY BRESP/RRESP is passed through unchanged; the FSM flow is identical.
//  ARESETN low at any point: immediate return to IDLE, all VALIDs = 0, pending response is dropped.
//  Minimum latency with a zero-wait slave: write cmd -> rsp_valid in 4 cycles; read cmd -> rsp_valid in 4 cycles.
// TESTING
//  Write addr 0x8, data 0xDEADBEEF, strb 0xF, ready slave -> one AW+W beat, AWADDR=0x8; rsp_valid with rsp_resp=0; slave reg2 reads back 0xDEADBEEF.
//  Read addr 0x4, slave RDATA=0x12345678 after 3 wait cycles -> RREADY held; rsp_rdata=0x12345678, rsp_resp=0.
//  WREADY 5 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held until WREADY; exactly one B handshake.
//  BRESP=2'b10 -> rsp_resp=2'b10; rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0 throughout.
//  TIMEOUT_CYCLES=16, ARREADY withheld 40 cycles -> timeout_err=1 at cycle 16, ARVALID held; flag cleared on next command.
//  ARESETN low during WRESP -> all VALIDs=0, cmd_ready=1 after release, next command completes normally.

Source files
------------

// File: rtl/axi4lite_cmd_master.sv
// AXI4-Lite master that turns one command/response handshake into a single
// AXI4-Lite read or write transaction, with a sticky stall watchdog.
module axi4lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              timeout_err
);

    localparam int DW    = C_M_AXI_DATA_WIDTH;
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int SW    = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    logic             aw_hs, w_hs, busy;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_d     = timeout_q;
        cmd_ready     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        rsp_valid     = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        busy          = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    timeout_d = 1'b0;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WADDR;
                    end else begin
                        state_d = S_RADDR;
                    end
                end
            end
            // AW and W complete independently; leave only once both have.
            S_WADDR: begin
                busy          = 1'b1;
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
                w_hs          = M_AXI_WVALID && M_AXI_WREADY;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WRESP;
            end
            S_WRESP: begin
                busy         = 1'b1;
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RADDR: begin
                busy          = 1'b1;
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_d = S_RDATA;
            end
            S_RDATA: begin
                busy         = 1'b1;
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog only observes; a stalled transaction is never withdrawn.
        if (TIMEOUT_CYCLES == 0 || !busy || state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != CNT_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (wd_cnt_q == CNT_MAX - 1'b1) timeout_d = 1'b1;
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed bench for axi4lite_cmd_master: a small delay-configurable AXI4-Lite
// slave with four registers, a handshake monitor and a linear stimulus sequence.
`timescale 1ns/1ps
module tb_axi4lite_cmd_master;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
    logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic            M_AXI_RVALID, M_AXI_RREADY;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid, rsp_ready, timeout_err;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;

    axi4lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(DW),
        .C_M_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .M_AXI_AWADDR (M_AXI_AWADDR),
        .M_AXI_AWPROT (M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA  (M_AXI_WDATA),
        .M_AXI_WSTRB  (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_WREADY (M_AXI_WREADY),
        .M_AXI_BRESP  (M_AXI_BRESP),
        .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BREADY (M_AXI_BREADY),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARPROT (M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .timeout_err  (timeout_err)
    );

    // Slave knobs, written only by the stimulus block.
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // ---------------- AXI4-Lite slave model ----------------
    int              aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic            aw_have, w_have, b_pend, r_pend;
    logic [AW-1:0]   aw_l, ar_l;
    logic [DW-1:0]   w_data_l;
    logic [DW/8-1:0] w_strb_l;
    logic [DW-1:0]   regs [4];
    logic            wr_fire;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_delay);
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_delay);
    assign wr_fire       = aw_have && w_have && !b_pend && !M_AXI_BVALID;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_l <= '0; ar_l <= '0; w_data_l <= '0; w_strb_l <= '0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_cnt <= 0; aw_have <= 1'b1; aw_l <= M_AXI_AWADDR;
            end else if (M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_cnt <= 0; w_have <= 1'b1; w_data_l <= M_AXI_WDATA; w_strb_l <= M_AXI_WSTRB;
            end else if (M_AXI_WVALID) w_cnt <= w_cnt + 1;
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_cnt <= 0; r_pend <= 1'b1; r_cnt <= 0; ar_l <= M_AXI_ARADDR;
            end else if (M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;

            if (wr_fire) begin
                aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end
            if (b_pend) begin
                if (b_cnt >= b_delay) begin
                    M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= bresp_cfg; b_pend <= 1'b0;
                end else b_cnt <= b_cnt + 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;

            if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    M_AXI_RVALID <= 1'b1; M_AXI_RDATA <= regs[ar_l[3:2]];
                    M_AXI_RRESP <= rresp_cfg; r_pend <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (wr_fire)
            for (int i = 0; i < 4; i++)
                if (w_strb_l[i]) regs[aw_l[3:2]][8*i +: 8] <= w_data_l[8*i +: 8];
    end

    // ---------------- Handshake monitor ----------------
    int            aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, viol = 0;
    logic          aw_p, w_p, ar_p;
    logic [AW-1:0] awaddr_p, araddr_p;
    logic [DW-1:0] wdata_p;

    always @(posedge clk) begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs_n <= aw_hs_n + 1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_hs_n  <= w_hs_n + 1;
        if (M_AXI_BVALID && M_AXI_BREADY)   b_hs_n  <= b_hs_n + 1;
    end

    // A VALID that was pending must still be up with unchanged payload.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_p <= 1'b0; w_p <= 1'b0; ar_p <= 1'b0;
            awaddr_p <= '0; araddr_p <= '0; wdata_p <= '0;
        end else begin
            viol <= viol
                + int'(aw_p && !(M_AXI_AWVALID && M_AXI_AWADDR == awaddr_p))
                + int'(w_p  && !(M_AXI_WVALID  && M_AXI_WDATA  == wdata_p))
                + int'(ar_p && !(M_AXI_ARVALID && M_AXI_ARADDR == araddr_p));
            aw_p <= M_AXI_AWVALID && !M_AXI_AWREADY;
            w_p  <= M_AXI_WVALID  && !M_AXI_WREADY;
            ar_p <= M_AXI_ARVALID && !M_AXI_ARREADY;
            awaddr_p <= M_AXI_AWADDR; araddr_p <= M_AXI_ARADDR; wdata_p <= M_AXI_WDATA;
        end
    end

    // ---------------- Checking helpers ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd;
    logic [1:0]  rr;
    int          aw0, w0, b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns one negedge after the accepting clock edge.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd  wr=%0d addr=0x%0h wdata=0x%08h wstrb=0x%0h", wr, a, d, s);
    endtask

    task automatic get_rsp(output logic [31:0] o_rd, output logic [1:0] o_rr);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        o_rd = rsp_rdata;
        o_rr = rsp_resp;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("rsp  rdata=0x%08h resp=%0d", o_rd, o_rr);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    // ---------------- Directed sequence ----------------
    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valids", {26'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                           M_AXI_BREADY, M_AXI_RREADY, rsp_valid}, 32'd0);
        chk("rst_regs", {M_AXI_WDATA | rsp_rdata} | {24'd0, M_AXI_AWADDR, M_AXI_WSTRB}, 32'd0);
        chk("rst_flags", {25'd0, timeout_err, rsp_resp, M_AXI_AWPROT | M_AXI_ARPROT}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write 0x8 <- DEADBEEF through a zero-wait slave, then read it back.
        aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        send_cmd(1'b1, 4'h8, 32'hDEADBEEF, 4'hF);
        chk("t1_valids", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        chk("t1_awaddr", {28'd0, M_AXI_AWADDR}, 32'h8);
        chk("t1_wdata", M_AXI_WDATA, 32'hDEADBEEF);
        chk("t1_wstrb", {28'd0, M_AXI_WSTRB}, 32'hF);
        chk("t1_busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        get_rsp(rd, rr);
        chk("t1_resp", {30'd0, rr}, 32'd0);
        chk("t1_rdata_zero", rd, 32'd0);
        chk("t1_beats", (aw_hs_n - aw0) * 100 + (w_hs_n - w0) * 10 + (b_hs_n - b0), 32'd111);
        send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
        chk("t1_araddr", {27'd0, M_AXI_ARVALID, M_AXI_ARADDR}, 32'h18);
        get_rsp(rd, rr);
        chk("t1_readback", rd, 32'hDEADBEEF);

        // Read 0x4 with the slave holding RDATA back 3 cycles.
        send_cmd(1'b1, 4'h4, 32'h12345678, 4'hF);
        get_rsp(rd, rr);
        r_delay = 3;
        send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        @(negedge clk);
        chk("t2_rready_wait1", {30'd0, M_AXI_RREADY, M_AXI_RVALID}, 32'd2);
        repeat (2) @(negedge clk);
        chk("t2_rready_wait3", {30'd0, M_AXI_RREADY, M_AXI_RVALID}, 32'd2);
        get_rsp(rd, rr);
        chk("t2_rdata", rd, 32'h12345678);
        chk("t2_resp", {30'd0, rr}, 32'd0);
        r_delay = 0;

        // Partial strobes, then a DECERR read passed straight through.
        send_cmd(1'b1, 4'h4, 32'hAABBCCDD, 4'b0101);
        get_rsp(rd, rr);
        rresp_cfg = 2'b11;
        send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        get_rsp(rd, rr);
        chk("t2_strobe_merge", rd, 32'h12BB56DD);
        chk("t2_decerr", {30'd0, rr}, 32'd3);
        rresp_cfg = 2'b00;

        // WREADY five cycles behind AWREADY.
        w_delay = 5;
        aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        send_cmd(1'b1, 4'hC, 32'h0F0F0F0F, 4'hF);
        chk("t3_both_up", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd3);
        @(negedge clk);
        chk("t3_aw_dropped", {30'd0, M_AXI_AWVALID, M_AXI_WVALID}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_w_held", {30'd0, M_AXI_WVALID, cmd_ready}, 32'd2);
        get_rsp(rd, rr);
        chk("t3_beats", (aw_hs_n - aw0) * 100 + (w_hs_n - w0) * 10 + (b_hs_n - b0), 32'd111);
        w_delay = 0;

        // SLVERR write response with the consumer stalling for 10 cycles.
        bresp_cfg = 2'b10;
        send_cmd(1'b1, 4'h0, 32'h00000055, 4'hF);
        for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
        chk("t4_rsp_up", {30'd0, rsp_valid, rsp_resp == 2'b10}, 32'd3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_stall_hold", {rsp_rdata[27:0], rsp_valid, cmd_ready, rsp_resp}, 32'b1010);
        end
        get_rsp(rd, rr);
        chk("t4_slverr", {30'd0, rr}, 32'd2);
        bresp_cfg = 2'b00;

        // ARREADY withheld 40 cycles: flag rises after exactly 16 stalled cycles.
        ar_delay = 40;
        send_cmd(1'b0, 4'h0, 32'h0, 4'h0);
        repeat (15) @(negedge clk);
        chk("t5_before_limit", {30'd0, timeout_err, M_AXI_ARVALID}, 32'd1);
        @(negedge clk);
        chk("t5_at_limit", {30'd0, timeout_err, M_AXI_ARVALID}, 32'd3);
        get_rsp(rd, rr);
        chk("t5_rdata", rd, 32'h00000055);
        chk("t5_sticky", {31'd0, timeout_err}, 32'd1);
        ar_delay = 0;
        send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
        chk("t5_cleared", {31'd0, timeout_err}, 32'd0);
        get_rsp(rd, rr);
        chk("t5_next_rdata", rd, 32'hDEADBEEF);

        // Reset asserted while waiting on B.
        b_delay = 8;
        send_cmd(1'b1, 4'h4, 32'h77777777, 4'hF);
        for (int n = 0; n < 50 && !M_AXI_BREADY; n++) @(negedge clk);
        @(negedge clk);
        chk("t6_in_wresp", {30'd0, M_AXI_BREADY, M_AXI_BVALID}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valids", {26'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                              M_AXI_BREADY, M_AXI_RREADY, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_delay = 0;
        @(negedge clk);
        chk("t6_idle_after", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        send_cmd(1'b1, 4'hC, 32'hCAFEF00D, 4'hF);
        get_rsp(rd, rr);
        chk("t6_wr_resp", {30'd0, rr}, 32'd0);
        send_cmd(1'b0, 4'hC, 32'h0, 4'h0);
        get_rsp(rd, rr);
        chk("t6_readback", rd, 32'hCAFEF00D);

        chk("protocol_violations", viol, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
